// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame parser: state encoding, sync byte, default payload limit.
package uart_frame_pkg;
  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_DRAIN
  } state_t;

  localparam logic [7:0] SYNC_BYTE       = 8'hA5;
  localparam int         DEFAULT_MAX_LEN = 64;
endpackage

// File: rtl/frame_buf.sv
// Payload store: DEPTH x 8 single-clock RAM, one write port, one registered read port.
module frame_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/uart_frame_parser.sv
// Parses A5/LEN/payload/XOR-checksum frames from a uart_rx byte handshake and drains verified payloads.
// Optional build macro FRAME_TIMEOUT_EN adds an inter-byte timeout inside a frame.
module uart_frame_parser #(
  parameter int MAX_LEN        = uart_frame_pkg::DEFAULT_MAX_LEN,
  parameter int TIMEOUT_CYCLES = 28125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_available,
  output logic       rx_clear_available,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err
);
  import uart_frame_pkg::*;

  localparam int         AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);

  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("uart_frame_parser: parameter out of range");
  end

  state_t     state, state_d;
  logic [7:0] byte_q, len_q, csum_q, cnt_q, rd_idx_q;
  logic       take, got, advance, wr_en, rd_en;
  logic       ok_d, err_d, timeout;
  logic [7:0] rd_data;

  // A byte is latched on the consuming edge and processed in the following
  // cycle, which is exactly the cycle rx_clear_available is high.
  assign got     = rx_clear_available;
  assign take    = rx_available && !rx_clear_available && (state != ST_DRAIN);
  assign advance = (state == ST_DRAIN) && (!out_valid || out_ready);
  assign rd_en   = advance && (rd_idx_q != len_q);

  always_comb begin
    state_d = state;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    case (state)
      ST_HUNT:    if (got && byte_q == SYNC_BYTE) state_d = ST_LEN;
      ST_LEN:     if (got) begin
                    if (byte_q == 8'd0 || byte_q > MAX_LEN8) begin
                      err_d   = 1'b1;
                      state_d = ST_HUNT;
                    end else begin
                      state_d = ST_PAYLOAD;
                    end
                  end
      ST_PAYLOAD: if (got) begin
                    wr_en = 1'b1;
                    if (cnt_q == len_q - 8'd1) state_d = ST_CSUM;
                  end
      ST_CSUM:    if (got) begin
                    if (byte_q == csum_q) begin
                      ok_d    = 1'b1;
                      state_d = ST_DRAIN;
                    end else begin
                      err_d   = 1'b1;
                      state_d = ST_HUNT;
                    end
                  end
      ST_DRAIN:   if (advance && rd_idx_q == len_q) state_d = ST_HUNT;
      default:    state_d = ST_HUNT;
    endcase
    if (timeout) begin
      err_d   = 1'b1;
      state_d = ST_HUNT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_HUNT;
      rx_clear_available <= 1'b0;
      byte_q             <= 8'd0;
      len_q              <= 8'd0;
      csum_q             <= 8'd0;
      cnt_q              <= 8'd0;
      rd_idx_q           <= 8'd0;
      out_valid          <= 1'b0;
      out_last           <= 1'b0;
      frame_ok           <= 1'b0;
      frame_err          <= 1'b0;
    end else begin
      state              <= state_d;
      rx_clear_available <= take;
      if (take) byte_q <= rx_data;
      frame_ok  <= ok_d;
      frame_err <= err_d;
      if (state == ST_LEN && got) begin
        len_q  <= byte_q;
        csum_q <= byte_q;
        cnt_q  <= 8'd0;
      end
      if (wr_en) begin
        csum_q <= csum_q ^ byte_q;
        cnt_q  <= cnt_q + 8'd1;
      end
      if (ok_d)  rd_idx_q <= 8'd0;
      if (rd_en) rd_idx_q <= rd_idx_q + 8'd1;
      // The RAM read register is the output register; it only moves on advance.
      if (advance) begin
        out_valid <= rd_en;
        out_last  <= rd_en && (rd_idx_q == len_q - 8'd1);
      end
    end
  end

  assign out_data = out_valid ? rd_data : 8'h00;

`ifdef FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          in_frame;

  assign in_frame = state inside {ST_LEN, ST_PAYLOAD, ST_CSUM};
  assign timeout  = in_frame && !take && !got && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || take || !in_frame) to_cnt <= '0;
    else if (!got)                to_cnt <= to_cnt + TW'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (cnt_q[AW-1:0]),
    .wr_data (byte_q),
    .rd_en   (rd_en),
    .rd_addr (rd_idx_q[AW-1:0]),
    .rd_data (rd_data)
  );
endmodule

// File: tb/tb_uart_frame_parser.sv
// Randomized bench for uart_frame_parser: uart_rx emulator, frame-level reference model, output scoreboard.
module tb_uart_frame_parser;
  localparam int MAX_LEN = 64;
  localparam int TO      = 200;

  logic       clk, rst;
  logic [7:0] rx_data;
  logic       rx_available, rx_clear_available;
  logic [7:0] out_data;
  logic       out_valid, out_ready, out_last, frame_ok, frame_err;

  uart_frame_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk                (clk),
    .rst                (rst),
    .rx_data            (rx_data),
    .rx_available       (rx_available),
    .rx_clear_available (rx_clear_available),
    .out_data           (out_data),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_last           (out_last),
    .frame_ok           (frame_ok),
    .frame_err          (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int ok_cnt = 0, err_cnt = 0, exp_ok = 0, exp_err = 0;
  int viol_drain = 0, viol_consec = 0;
  int rdy_mode = 0, max_gap = 0, cyc = 0;
  logic [7:0] tx_q[$];
  logic [7:0] pend[$];
  logic [8:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: consumes whole frames from the pending byte list.
  task automatic model_parse();
    int len;
    logic [7:0] x;
    while (1) begin
      while (pend.size() > 0 && pend[0] != 8'hA5) void'(pend.pop_front());
      if (pend.size() < 2) return;
      len = int'(pend[1]);
      if (len == 0 || len > MAX_LEN) begin
        exp_err++;
        void'(pend.pop_front());
        void'(pend.pop_front());
        continue;
      end
      if (pend.size() < len + 3) return;
      x = pend[1];
      for (int i = 0; i < len; i++) x ^= pend[2+i];
      if (x == pend[len+2]) begin
        exp_ok++;
        for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), pend[2+i]});
      end else begin
        exp_err++;
      end
      for (int i = 0; i < len + 3; i++) void'(pend.pop_front());
    end
  endtask

  task automatic push(input logic [7:0] b);
    tx_q.push_back(b);
    pend.push_back(b);
    model_parse();
  endtask

  task automatic send_frame(input int len, input bit bad);
    logic [7:0] x, b;
    push(8'hA5);
    push(8'(len));
    x = 8'(len);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      x ^= b;
      push(b);
    end
    push(bad ? (x ^ 8'($urandom_range(1, 255))) : x);
  endtask

  task automatic wait_idle(input string tag);
    int quiet = 0, n = 0;
    while (quiet < 6 && n < 20000) begin
      @(posedge clk); #1;
      n++;
      if (tx_q.size() == 0 && !rx_available && !rx_clear_available && !out_valid) quiet++;
      else quiet = 0;
    end
    chk({tag, "_idle"}, 32'(n < 20000), 32'd1);
    chk({tag, "_ok"}, ok_cnt, exp_ok);
    chk({tag, "_err"}, err_cnt, exp_err);
    chk({tag, "_outq"}, exp_q.size(), 0);
  endtask

  task automatic wait_rx_drained(input string tag);
    int n = 0;
    while (!(tx_q.size() == 0 && !rx_available && !rx_clear_available) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_drained"}, 32'(n < 5000), 32'd1);
  endtask

  // uart_rx emulator: drops available the edge after it sees the clear pulse.
  initial begin
    bit pend_drop;
    int gap;
    pend_drop = 0; gap = 0;
    rx_available = 1'b0; rx_data = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        pend_drop = 0;
      end else if (pend_drop) begin
        rx_available = 1'b0;
        pend_drop = 0;
        gap = $urandom_range(0, max_gap);
      end else if (!rx_available && gap > 0) begin
        gap--;
      end else if (!rx_available && tx_q.size() > 0) begin
        rx_data = tx_q.pop_front();
        rx_available = 1'b1;
      end
      if (rx_clear_available) pend_drop = 1;
    end
  end

  initial begin
    int tog;
    tog = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1:       out_ready = 1'($urandom_range(0, 1));
        2:       begin out_ready = (tog == 0); tog = (tog + 1) % 3; end
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Output monitor / scoreboard.
  initial begin
    bit prev_stall, prev_clr, draining, first;
    logic [7:0] held_d;
    logic held_l;
    logic [8:0] e;
    int ok_cyc, prev_x;
    prev_stall = 0; prev_clr = 0; draining = 0; first = 0;
    held_d = 0; held_l = 0; ok_cyc = 0; prev_x = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_stall = 0; prev_clr = 0; draining = 0;
        continue;
      end
      if (frame_err) err_cnt++;
      if (rx_clear_available && prev_clr) viol_consec++;
      if (draining && rx_clear_available) viol_drain++;
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(held_d));
        chk("hold_last", 32'(out_last), 32'(held_l));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e[7:0]));
          chk("out_last", 32'(out_last), 32'(e[8]));
        end
        if (rdy_mode == 0) begin
          if (first) chk("first_latency", cyc, ok_cyc + 1);
          else       chk("burst_rate", cyc, prev_x + 1);
        end
        prev_x = cyc;
        first = 0;
        if (out_last) draining = 0;
      end
      if (frame_ok) begin
        ok_cnt++;
        ok_cyc = cyc;
        first = 1;
        draining = 1;
      end
      prev_stall = out_valid && !out_ready;
      held_d = out_data;
      held_l = out_last;
      prev_clr = rx_clear_available;
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_clear", 32'(rx_clear_available), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ok", 32'(frame_ok), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    rst = 1'b0;

    // Directed frames with out_ready held high.
    max_gap = 2;
    push(8'hA5); push(8'h03); push(8'h41); push(8'h42); push(8'h43); push(8'h43);
    wait_idle("good3");
    push(8'hA5); push(8'h03); push(8'h41); push(8'h42); push(8'h43); push(8'h00);
    wait_idle("badcsum");
    push(8'h00); push(8'hFF); push(8'hA5); push(8'h01); push(8'h5A); push(8'h5B);
    wait_idle("junk");
    push(8'hA5); push(8'h00); push(8'hA5); push(8'h41);
    push(8'hA5); push(8'h02); push(8'h10); push(8'h20); push(8'h32);
    wait_idle("badlen");
    send_frame(MAX_LEN, 0);
    wait_idle("maxlen");
    push(8'hA5); push(8'(MAX_LEN + 1)); send_frame(1, 0);
    wait_idle("overlen");

    // Toggling backpressure with the next frame queued behind the drain.
    max_gap = 0;
    rdy_mode = 2;
    send_frame(3, 0); send_frame(3, 0);
    wait_idle("toggle");

    // Randomized mix of frames, junk and malformed frames.
    for (int r = 0; r < 4; r++) begin
      rdy_mode = (r == 0) ? 0 : int'($urandom_range(0, 1));
      max_gap  = int'($urandom_range(0, 3));
      for (int k = 0; k < 10; k++) begin
        int kind;
        logic [7:0] b;
        kind = int'($urandom_range(0, 9));
        if (kind == 0) begin
          for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
            b = 8'($urandom);
            push((b == 8'hA5) ? 8'h00 : b);
          end
        end else if (kind == 1) begin
          push(8'hA5);
          push(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
        end else if (kind == 2) begin
          send_frame(int'($urandom_range(1, 8)), 1);
        end else begin
          send_frame((kind == 9) ? int'($urandom_range(1, MAX_LEN)) : int'($urandom_range(1, 6)), 0);
        end
      end
      wait_idle("rand");
    end

    // Partial frame left idle.
    rdy_mode = 0;
    push(8'hA5); push(8'h03); push(8'h41);
    wait_rx_drained("partial");
`ifdef FRAME_TIMEOUT_EN
    repeat (TO - 30) @(posedge clk);
    chk("no_early_timeout", err_cnt, exp_err);
    exp_err++;
    pend.delete();
    for (int n = 0; n < 100 && err_cnt != exp_err; n++) @(posedge clk);
    #1;
    chk("timeout_err", err_cnt, exp_err);
`else
    repeat (300) @(posedge clk);
    chk("no_timeout", err_cnt, exp_err);
    push(8'h42); push(8'h43); push(8'h43);
    wait_idle("resume");
`endif

    // Reset mid-payload abandons the frame silently.
    push(8'hA5); push(8'h05); push(8'h01); push(8'h02);
    wait_rx_drained("midrst");
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_clear", 32'(rx_clear_available), 32'd0);
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_err", 32'(frame_err), 32'd0);
    chk("mrst_ok", 32'(frame_ok), 32'd0);
    rst = 1'b0;
    pend.delete();
    send_frame(2, 0);
    wait_idle("postrst");

    chk("drain_no_take", viol_drain, 0);
    chk("no_consec_take", viol_consec, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "time limit");
  end
endmodule
